// File: rtl/enc_gray_codec_pipe.sv
// Pipelined Gray-code codec: encode, decode, Gray increment and Gray decrement
// on a valid/ready stream, with a STAGES-deep backpressured register pipeline.
module enc_gray_codec_pipe #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode
);

  localparam int unsigned MODE_W = 2;
  localparam logic [MODE_W-1:0] MODE_DEC = 2'b01;
  localparam logic [MODE_W-1:0] MODE_INC = 2'b10;
  localparam logic [MODE_W-1:0] MODE_DCR = 2'b11;

  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [MODE_W-1:0] mode_q [STAGES];
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  in_bin;
  logic [WIDTH-1:0]  result;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Operation datapath, evaluated on the word presented at the input
  always_comb begin
    in_bin = gray2bin(in_data);
    result = bin2gray(in_data);
    case (in_mode)
      MODE_DEC: result = in_bin;
      MODE_INC: result = bin2gray(in_bin + WIDTH'(1));
      MODE_DCR: result = bin2gray(in_bin - WIDTH'(1));
      default:  ;
    endcase
  end

  // A stage may load unless it and every stage after it are full and the output is stalled
  always_comb begin
    logic tail_full;
    tail_full = 1'b1;
    adv       = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      tail_full = tail_full & valid_q[k];
      adv[k]    = out_ready | ~tail_full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        data_q[k] <= '0;
        mode_q[k] <= '0;
      end
    end else begin
      if (adv[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= result;
          mode_q[0] <= in_mode;
        end
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (adv[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            data_q[k] <= data_q[k-1];
            mode_q[k] <= mode_q[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];

endmodule

// File: tb/tb_enc_gray_codec_pipe.sv
// Bench for enc_gray_codec_pipe: five parameterisations driven together and checked
// every cycle against a queue-based behavioural model.
module tb_enc_gray_codec_pipe;

  localparam int NI = 5;
  localparam int WS [NI] = '{10, 10, 2, 16, 32};
  localparam int SS [NI] = '{2, 3, 1, 8, 8};

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [1:0]  in_mode;
  logic [31:0] din [NI];

  logic        rdy [NI];
  logic        ov  [NI];
  logic [31:0] od  [NI];
  logic [1:0]  om  [NI];

  logic [9:0]  od0, od1;
  logic [1:0]  od2;
  logic [15:0] od3;
  logic [31:0] od4;

  enc_gray_codec_pipe #(.WIDTH(10), .STAGES(2)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_mode(in_mode),
    .in_data(din[0][9:0]), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0), .out_mode(om[0]));
  enc_gray_codec_pipe #(.WIDTH(10), .STAGES(3)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_mode(in_mode),
    .in_data(din[1][9:0]), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1), .out_mode(om[1]));
  enc_gray_codec_pipe #(.WIDTH(2), .STAGES(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_mode(in_mode),
    .in_data(din[2][1:0]), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od2), .out_mode(om[2]));
  enc_gray_codec_pipe #(.WIDTH(16), .STAGES(8)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]), .in_mode(in_mode),
    .in_data(din[3][15:0]), .out_valid(ov[3]), .out_ready(out_ready), .out_data(od3), .out_mode(om[3]));
  enc_gray_codec_pipe #(.WIDTH(32), .STAGES(8)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[4]), .in_mode(in_mode),
    .in_data(din[4]), .out_valid(ov[4]), .out_ready(out_ready), .out_data(od4), .out_mode(om[4]));

  assign od[0] = 32'(od0);
  assign od[1] = 32'(od1);
  assign od[2] = 32'(od2);
  assign od[3] = 32'(od3);
  assign od[4] = od4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: per-instance FIFO of expected results with their acceptance edge
  logic [31:0] exp_d [NI][16];
  logic [1:0]  exp_m [NI][16];
  int          exp_c [NI][16];
  int          hd  [NI];
  int          cnt [NI];

  int          dut_in  [NI];
  int          dut_out [NI];
  logic [31:0] last_out [NI];
  logic [31:0] prev_out [NI];
  logic [31:0] obs0 [$];

  function automatic logic [31:0] msk(int w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [31:0] m_gray(int w, logic [31:0] b);
    return (b ^ (b >> 1)) & msk(w);
  endfunction

  // Binary bit i is the parity of all Gray bits at and above i
  function automatic logic [31:0] m_ungray(int w, logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < w; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [31:0] m_op(int w, logic [1:0] m, logic [31:0] x);
    logic [31:0] v;
    v = x & msk(w);
    case (m)
      2'd0:    return m_gray(w, v);
      2'd1:    return m_ungray(w, v);
      2'd2:    return m_gray(w, (m_ungray(w, v) + 32'd1) & msk(w));
      default: return m_gray(w, (m_ungray(w, v) - 32'd1) & msk(w));
    endcase
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc%0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  task automatic set_data(logic [31:0] v);
    for (int k = 0; k < NI; k++) din[k] = v;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NI; k++) begin
      hd[k]  = 0;
      cnt[k] = 0;
    end
  endtask

  // One clock: compare all DUT outputs with the model, then advance across the edge
  task automatic step();
    logic        ix [NI];
    logic        ox [NI];
    logic [31:0] nd [NI];
    logic [1:0]  md;
    #1;
    md = in_mode;
    for (int k = 0; k < NI; k++) begin
      logic er, ev;
      int   h;
      h  = hd[k];
      er = (cnt[k] < SS[k]) || out_ready;
      ev = (cnt[k] > 0) && (cyc - exp_c[k][h] >= SS[k] - 1);
      chk("in_ready", k, 32'(rdy[k]), 32'(er));
      chk("out_valid", k, 32'(ov[k]), 32'(ev));
      if (ev) begin
        chk("out_data", k, od[k], exp_d[k][h]);
        chk("out_mode", k, 32'(om[k]), 32'(exp_m[k][h]));
      end
      ix[k] = in_valid && er;
      ox[k] = out_ready && ev;
      nd[k] = m_op(WS[k], md, din[k]);
      if (in_valid && rdy[k]) dut_in[k]++;
      if (ov[k] && out_ready) begin
        dut_out[k]++;
        prev_out[k] = last_out[k];
        last_out[k] = od[k];
        if (k == 0) obs0.push_back(od[0]);
      end
    end
    @(posedge clk);
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (ox[k]) begin
        hd[k]  = (hd[k] + 1) % 16;
        cnt[k] = cnt[k] - 1;
      end
      if (ix[k]) begin
        int t;
        t = (hd[k] + cnt[k]) % 16;
        exp_d[k][t] = nd[k];
        exp_m[k][t] = md;
        exp_c[k][t] = cyc;
        cnt[k] = cnt[k] + 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] lit [6];
    logic [31:0] enc [1024];
    logic [31:0] held;
    int          base [NI];

    lit = '{32'h3FE, 32'h2AB, 32'h000, 32'h001, 32'h200, 32'h000};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_mode = 2'd0;
    set_data('0);
    clear_model();
    for (int k = 0; k < NI; k++) begin
      dut_in[k] = 0; dut_out[k] = 0; last_out[k] = '0; prev_out[k] = '0;
    end

    // Anchor the reference model on hand-computed values
    chk("model_enc", 0, m_op(10, 2'd0, 32'h2AB), 32'h3FE);
    chk("model_dec", 0, m_op(10, 2'd1, 32'h3FE), 32'h2AB);
    chk("model_dec_wrap", 0, m_op(10, 2'd3, 32'h000), 32'h200);

    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_out_valid", k, 32'(ov[k]), 32'd0);
      chk("rst_out_data", k, od[k], 32'd0);
      chk("rst_out_mode", k, 32'(om[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed encode/decode and wrap boundaries
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode = 2'd0; set_data(32'h2AB); step();
    in_mode = 2'd1; set_data(32'h3FE); step();
    in_mode = 2'd2; set_data(32'h200); step();
    in_mode = 2'd2; set_data(32'h000); step();
    in_mode = 2'd3; set_data(32'h000); step();
    in_mode = 2'd3; set_data(32'h001); step();
    in_valid = 1'b0;
    repeat (10) step();
    chk("directed_count", 0, 32'(obs0.size()), 32'd6);
    for (int i = 0; i < 6; i++) if (i < obs0.size()) chk("directed_lit", 0, obs0[i], lit[i]);

    // Parameter sweep: increment of the top Gray code wraps to 0, encode of 1 is 1
    in_valid = 1'b1;
    in_mode  = 2'd2;
    for (int k = 0; k < NI; k++) din[k] = 32'(64'd1 << (WS[k] - 1));
    step();
    in_mode = 2'd0; set_data(32'd1); step();
    in_valid = 1'b0;
    repeat (12) step();
    for (int k = 0; k < NI; k++) begin
      chk("sweep_inc_wrap", k, prev_out[k], 32'd0);
      chk("sweep_enc_one", k, last_out[k], 32'd1);
    end

    // Exhaustive round trip on the 10-bit, 2-stage instance
    obs0.delete();
    in_valid = 1'b1;
    in_mode  = 2'd0;
    for (int i = 0; i < 1024; i++) begin set_data(32'(i)); step(); end
    in_valid = 1'b0;
    repeat (10) step();
    chk("rt_enc_count", 0, 32'(obs0.size()), 32'd1024);
    for (int i = 0; i < 1024; i++) enc[i] = (i < obs0.size()) ? obs0[i] : 32'd0;
    obs0.delete();
    in_valid = 1'b1;
    in_mode  = 2'd1;
    for (int i = 0; i < 1024; i++) begin set_data(enc[i]); step(); end
    in_valid = 1'b0;
    repeat (10) step();
    chk("rt_dec_count", 0, 32'(obs0.size()), 32'd1024);
    for (int i = 0; i < 1024; i++) if (i < obs0.size()) chk("round_trip", 0, obs0[i], 32'(i));

    // Capacity under full stall, then hold stability
    for (int k = 0; k < NI; k++) base[k] = dut_in[k];
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_mode = 2'($urandom); set_data($urandom); step();
    end
    for (int k = 0; k < NI; k++) chk("stall_capacity", k, 32'(dut_in[k] - base[k]), 32'(SS[k]));
    held = od[1];
    repeat (4) step();
    chk("stall_hold", 1, od[1], held);

    // Random traffic with random backpressure
    for (int i = 0; i < 500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_mode   = 2'($urandom);
      set_data($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) step();
    for (int k = 0; k < NI; k++) chk("no_loss_dup", k, 32'(dut_out[k]), 32'(dut_in[k]));

    // Asynchronous reset with two words in flight
    in_valid = 1'b1;
    in_mode  = 2'd0;
    set_data(32'h0AA); step();
    set_data(32'h0BB); step();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("async_rst_valid", k, 32'(ov[k]), 32'd0);
      chk("async_rst_data", k, od[k], 32'd0);
      chk("async_rst_mode", k, 32'(om[k]), 32'd0);
    end
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    obs0.delete();
    in_valid = 1'b1;
    set_data(32'h155); step();
    in_valid = 1'b0;
    repeat (12) step();
    chk("post_rst_count", 0, 32'(obs0.size()), 32'd1);
    if (obs0.size() > 0) chk("post_rst_data", 0, obs0[0], 32'h1FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
